// File: rtl/regfile_dataflow_pkg.sv
// Shared sizing constants and word types for the 32 x 32 register file.
package regfile_dataflow_pkg;

    localparam int REGFILE_DEPTH = 32;
    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_decoder.sv
// One-hot write-enable decoder. Entry 0 never asserts because r0 is a hard zero.
module regfile_decoder
    import regfile_dataflow_pkg::*;
(
    input  logic                     we_i,
    input  addr_t                    wn_i,
    output logic [REGFILE_DEPTH-1:0] wen_o
);

    always_comb begin
        wen_o = '0;
        if (we_i) begin
            wen_o[wn_i] = 1'b1;
        end
        wen_o[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_dataflow.sv
// Two-read, one-write register file with r0 hardwired to zero.
// Reads are combinational and do not forward the data being written in the same cycle.
module regfile_dataflow
    import regfile_dataflow_pkg::*;
(
    input  logic  clk,
    input  logic  clrn,
    input  addr_t rna,
    input  addr_t rnb,
    input  addr_t wn,
    input  data_t d,
    input  logic  we,
    output data_t qa,
    output data_t qb
);

    logic [REGFILE_DEPTH-1:0] wen;
    data_t                    regs_q [1:REGFILE_DEPTH-1];
    data_t                    regs_d [1:REGFILE_DEPTH-1];
    data_t                    rd_vec [REGFILE_DEPTH];

    regfile_decoder u_decoder (
        .we_i  (we),
        .wn_i  (wn),
        .wen_o (wen)
    );

    // Reset wins over a write that arrives on the same edge.
    always_comb begin
        for (int i = 1; i < REGFILE_DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (!clrn) begin
                regs_d[i] = '0;
            end else if (wen[i]) begin
                regs_d[i] = d;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < REGFILE_DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Full 32-entry view so that both read multiplexers see a constant zero at address 0.
    assign rd_vec[0] = '0;
    generate
        for (genvar gi = 1; gi < REGFILE_DEPTH; gi++) begin : g_rd
            assign rd_vec[gi] = regs_q[gi];
        end
    endgenerate

    assign qa = rd_vec[rna];
    assign qb = rd_vec[rnb];

endmodule

// File: tb/tb_regfile_dataflow.sv
// Self-checking bench: directed scenarios plus random traffic against an array model.
module tb_regfile_dataflow;

    logic        clk = 1'b0;
    logic        clrn;
    logic        we;
    logic [4:0]  rna, rnb, wn;
    logic [31:0] d, qa, qb;

    logic [31:0] model [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_dataflow dut (
        .clk  (clk),
        .clrn (clrn),
        .rna  (rna),
        .rnb  (rnb),
        .wn   (wn),
        .d    (d),
        .we   (we),
        .qa   (qa),
        .qb   (qb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic step();
        @(posedge clk);
        if (!clrn) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wn != 5'd0) begin
            model[wn] = d;
        end
        #1;
    endtask

    // Sweep every address on both ports; writes are disabled so edges during the sweep are harmless.
    task automatic scan(input string tag);
        we   = 1'b0;
        clrn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i);
            rnb = 5'(31 - i);
            #1;
            chk({tag, "_qa"}, qa, model[i]);
            chk({tag, "_qb"}, qb, model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        clrn = 1'b0; we = 1'b0; wn = '0; d = '0; rna = '0; rnb = '0;
        step();
        scan("reset");

        // Three successive writes, then read back
        clrn = 1'b1; we = 1'b1;
        wn = 5'd12; d = 32'd12; step();
        wn = 5'd5;  d = 32'd5;  step();
        wn = 5'd10; d = 32'd10; step();
        we = 1'b0; rna = 5'd10; rnb = 5'd5; #1;
        chk("seq_qa10", qa, 32'd10);
        chk("seq_qb5", qb, 32'd5);
        rnb = 5'd12; #1;
        chk("seq_qb12", qb, 32'd12);

        // Same-cycle read of the write target shows the old value
        rna = 5'd10; we = 1'b1; wn = 5'd10; d = 32'd30; #1;
        chk("nobypass_pre", qa, 32'd10);
        step();
        chk("nobypass_post", qa, 32'd30);

        // Write to r0 is discarded
        we = 1'b1; wn = 5'd0; d = 32'hFFFF_FFFF; rna = 5'd0; step();
        chk("r0_write", qa, 32'h0);
        scan("r0_nochange");

        // we=0 leaves the target untouched
        clrn = 1'b1; we = 1'b1; wn = 5'd7; d = 32'h0000_1234; step();
        we = 1'b0; wn = 5'd7; d = 32'hDEAD_BEEF; rna = 5'd7; step();
        chk("we0_r7", qa, 32'h0000_1234);

        // Reset beats a simultaneous write; the next edge writes normally
        clrn = 1'b0; we = 1'b1; wn = 5'd3; d = 32'd99; rna = 5'd3; rnb = 5'd7; step();
        chk("rst_prio_r3", qa, 32'h0);
        chk("rst_prio_r7", qb, 32'h0);
        clrn = 1'b1; step();
        chk("rst_release_r3", qa, 32'd99);

        // Random traffic, including occasional resets and same-address reads
        for (int n = 0; n < 400; n++) begin
            rna  = 5'($urandom_range(0, 31));
            rnb  = ($urandom_range(0, 3) == 0) ? rna : 5'($urandom_range(0, 31));
            wn   = ($urandom_range(0, 2) == 0) ? rna : 5'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 1));
            d    = $urandom;
            clrn = ($urandom_range(0, 29) != 0);
            #1;
            chk("rand_pre_qa", qa, model[rna]);
            chk("rand_pre_qb", qb, model[rnb]);
            step();
            chk("rand_post_qa", qa, model[rna]);
            chk("rand_post_qb", qb, model[rnb]);
            if (rna == rnb) chk("rand_same_addr", qa, qb);
        end
        scan("rand_final");

        // One reset edge after arbitrary writes clears everything
        clrn = 1'b0; we = 1'b1; wn = 5'd31; d = $urandom; step();
        scan("reset_after_writes");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
